// File: rtl/systolic_c_drain.sv
// systolic_c_drain: snapshots the PE accumulator tile and streams it out row by row, requantised to OUT_W
module systolic_c_drain #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int ACC_W_P = 32,
  parameter int OUT_W   = 16,
  parameter int SH_W    = $clog2(ACC_W_P)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SH_W-1:0]                shift,
  input  logic [ROWS*COLS*ACC_W_P-1:0]   c_in,
  output logic                           clear_req,
  output logic                           busy,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [COLS*OUT_W-1:0]          m_data,
  output logic [$clog2(ROWS)-1:0]        m_row,
  output logic                           m_last,
  output logic                           done,
  output logic                           start_drop
);
  localparam int RW = $clog2(ROWS);
  localparam logic signed [ACC_W_P:0] MAXV = {{(ACC_W_P-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W_P:0] MINV = ~MAXV;
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t                         state_q, state_d;
  logic [RW-1:0]                  row_cnt_q, row_d;
  logic [ROWS*COLS*ACC_W_P-1:0]   buf_q;
  logic [SH_W-1:0]                shift_q;
  logic                           clear_q, done_q, drop_q;
  logic                           drain, last, fire, last_fire, capture;
  logic [COLS*ACC_W_P-1:0]        row_w;
  assign drain     = state_q == DRAIN;
  assign last      = row_cnt_q == RW'(ROWS-1);
  assign fire      = drain & m_ready;
  assign last_fire = fire & last;
  // a start coinciding with the final handshake is taken, so tiles chain without a bubble
  assign capture   = start & (~drain | last_fire);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      buf_q     <= '0;
      shift_q   <= '0;
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_d;
      clear_q   <= capture;
      done_q    <= last_fire;
      drop_q    <= start & drain & ~last_fire;
      if (capture) begin
        buf_q   <= c_in;
        shift_q <= shift;
      end
    end
  end
  always_comb begin
    state_d = capture ? DRAIN : last_fire ? IDLE : state_q;
    row_d   = (capture | last_fire) ? '0 : fire ? row_cnt_q + 1'b1 : row_cnt_q;
  end
  always_comb begin
    m_valid    = drain;
    busy       = drain;
    m_row      = row_cnt_q;
    m_last     = drain & last;
    clear_req  = clear_q;
    done       = done_q;
    start_drop = drop_q;
  end
  assign row_w = buf_q[row_cnt_q*(COLS*ACC_W_P) +: COLS*ACC_W_P];
  for (genvar c = 0; c < COLS; c++) begin : g_rq
    logic        [ACC_W_P:0] rnd;
    logic signed [ACC_W_P:0] sum, y;
    // one extra bit keeps the round-half-up add from wrapping
    assign rnd = shift_q == '0 ? '0 : {{ACC_W_P{1'b0}}, 1'b1} << (shift_q - SH_W'(1));
    assign sum = $signed({row_w[(c+1)*ACC_W_P-1], row_w[c*ACC_W_P +: ACC_W_P]}) + $signed(rnd);
    assign y   = sum >>> shift_q;
    assign m_data[c*OUT_W +: OUT_W] = y > MAXV ? MAXV[OUT_W-1:0] : y < MINV ? MINV[OUT_W-1:0] : y[OUT_W-1:0];
  end
endmodule

// File: tb/tb_systolic_c_drain.sv
// tb_systolic_c_drain: random tile/backpressure traffic checked every cycle against a tile-level model
module tb_systolic_c_drain;
  localparam int R = 8, C = 8, A = 32, O = 16, S = 5;
  logic             clk = 0, rst = 1, start = 0, m_ready = 0;
  logic [S-1:0]     shift = '0;
  logic [R*C*A-1:0] c_in = '0;
  logic             clear_req, busy, m_valid, m_last, done, start_drop;
  logic [C*O-1:0]   m_data;
  logic [2:0]       m_row;
  int total = 0, bad = 0, done_cnt = 0;
  bit     m_busy = 0, e_clr = 0, e_done = 0, e_drop = 0;
  int     mrow = 0;
  longint expq[R][C];
  systolic_c_drain #(.ROWS(R), .COLS(C), .ACC_W_P(A), .OUT_W(O)) dut (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .c_in(c_in),
    .clear_req(clear_req), .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_row(m_row), .m_last(m_last), .done(done), .start_drop(start_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask
  // round half up, arithmetic shift, clamp to signed OUT_W
  function automatic longint rq(longint x, int s);
    longint v = s == 0 ? x : (x + (longint'(1) << (s - 1))) >>> s;
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  function automatic logic [A-1:0] rand_acc();
    int k = $urandom_range(0, 3);
    return k == 0 ? A'($urandom) : k == 1 ? A'($urandom_range(0, 2000) - 1000) :
           k == 2 ? ($urandom_range(0, 1) ? 32'h7fffffff : 32'h80000000) :
           A'($signed($urandom) >>> $urandom_range(4, 24));
  endfunction
  task automatic rand_cin();
    for (int i = 0; i < R*C; i++) c_in[i*A +: A] = rand_acc();
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) expq[r][c] = 0;
  always @(negedge clk) begin
    bit fire, lf, acc;
    chk("valid", m_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("row", m_row, mrow);
    chk("last", m_last, m_busy && mrow == R-1);
    chk("clear_req", clear_req, e_clr);
    chk("done", done, e_done);
    chk("start_drop", start_drop, e_drop);
    for (int c = 0; c < C; c++) chk("data", $signed(m_data[c*O +: O]), expq[mrow][c]);
    if (done) done_cnt++;
    if (rst) begin
      m_busy = 0; mrow = 0; e_clr = 0; e_done = 0; e_drop = 0;
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) expq[r][c] = 0;
    end else begin
      fire = m_busy && m_ready;
      lf = fire && mrow == R-1;
      acc = start && (!m_busy || lf);
      e_clr = acc; e_done = lf; e_drop = start && m_busy && !lf;
      if (acc) begin
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++) expq[r][c] = rq($signed(c_in[(r*C+c)*A +: A]), int'(shift));
        m_busy = 1; mrow = 0;
      end else if (lf) begin
        m_busy = 0; mrow = 0;
      end else if (fire) mrow++;
    end
  end
  initial begin
    int d0;
    step(2);
    rst = 0;
    step(1);
    chk("rq_40", rq(40, 4), 3);
    chk("rq_m40", rq(-40, 4), -2);
    chk("rq_pos_sat", rq(64'sd1 << 30, 4), 32767);
    chk("rq_neg_sat", rq(-(64'sd1 << 30), 4), -32768);
    chk("rq_m24", rq(-24, 4), -1);
    chk("rq_s0", rq(-123, 0), -123);
    // basic ramp tile
    for (int i = 0; i < R*C; i++) c_in[i*A +: A] = A'(i);
    shift = 0; m_ready = 1; d0 = done_cnt;
    start = 1; step(); start = 0; rand_cin();
    step(3); #1;
    chk("basic_row3", m_row, 3);
    chk("basic_r3c5", $signed(m_data[5*O +: O]), 29);
    step(6);
    chk("basic_done_once", done_cnt - d0, 1);
    // rounding and saturation
    rand_cin();
    c_in[0 +: A] = 40; c_in[A +: A] = -40; c_in[2*A +: A] = 1 << 30; c_in[3*A +: A] = -(1 << 30);
    shift = 4; start = 1; step(); start = 0; rand_cin(); #1;
    chk("sat_clear", clear_req, 1);
    chk("sat_e0", $signed(m_data[0 +: O]), 3);
    chk("sat_e1", $signed(m_data[O +: O]), -2);
    chk("sat_e2", $signed(m_data[2*O +: O]), 32767);
    chk("sat_e3", $signed(m_data[3*O +: O]), -32768);
    step(10);
    // reset mid-drain
    d0 = done_cnt; rand_cin(); shift = 3;
    start = 1; step(); start = 0;
    step(3); rst = 1; step(2); rst = 0; #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_zero", |m_data, 0);
    step(3);
    chk("rst_no_done", done_cnt - d0, 0);
    // overlap: dropped start mid-tile, accepted start on last handshake
    rand_cin(); shift = 2;
    start = 1; step(); start = 0; rand_cin();
    step(2); start = 1; step(); start = 0; #1;
    chk("drop_pulse", start_drop, 1);
    chk("drop_row", m_row, 3);
    step(4); start = 1; shift = 5; step(); start = 0; rand_cin(); #1;
    chk("chain_clear", clear_req, 1);
    chk("chain_valid", m_valid, 1);
    chk("chain_row", m_row, 0);
    step(10);
    // random traffic with backpressure and c_in churning every cycle
    for (int i = 0; i < 600; i++) begin
      m_ready = $urandom_range(0, 9) >= 3;
      start = $urandom_range(0, 9) == 0;
      shift = S'($urandom_range(0, 31));
      rand_cin();
      step();
    end
    start = 0; m_ready = 1;
    step(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
